btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named CLK and the reset port RST.
REQ-002 Parameter N_BTN, default 3: number of independent button channels.
REQ-003 Parameter DEBOUNCE_CYCLES, default 12000: consecutive stable synchronized samples required to accept a change (1 ms at 12 MHz); legal range 2..2^20.
REQ-004 CLK  input  1  system clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 btn_raw  input  N_BTN  asynchronous, bouncing button pins; 1 = pressed.
REQ-007 btn_level  output  N_BTN  debounced button state, registered.
REQ-008 btn_press  output  N_BTN  one-cycle pulse on accepted 0->1 change, registered.
REQ-009 btn_release  output  N_BTN  one-cycle pulse on accepted 1->0 change, registered.

Function
REQ-010 Each channel SHALL pass btn_raw[i] through a two-flop synchronizer (s1 then s2); no other logic SHALL read btn_raw.
REQ-011 Each channel SHALL run an independent FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO plus a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 STABLE_LO: s2=1 -> WAIT_HI, count=1; otherwise stay, count=0.
REQ-013 WAIT_HI: s2=0 -> STABLE_LO, count=0 (bounce rejected, no output change); s2=1 and count=DEBOUNCE_CYCLES-1 -> STABLE_HI, btn_level=1, btn_press=1 for that cycle; otherwise count+1.
REQ-014 STABLE_HI / WAIT_LO SHALL mirror REQ-012/013 with polarity inverted, asserting btn_release and clearing btn_level on acceptance.
REQ-015 btn_level SHALL be 1 exactly in STABLE_HI and WAIT_LO.
REQ-016 Latency: counting the first rising edge that samples a new steady btn_raw value as edge 1, btn_level and the pulse SHALL update on edge DEBOUNCE_CYCLES+2.
REQ-017 Any glitch whose synchronized width is shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.
REQ-018 btn_press and btn_release SHALL each be high for exactly one cycle per accepted change, SHALL never be high together on one channel, and SHALL never be high on consecutive cycles on one channel.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-020 Channels SHALL NOT interact; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-021 While RST=1 at a rising edge: s1, s2, btn_level, btn_press, btn_release, and counters SHALL all be 0, and every FSM SHALL be in STABLE_LO.
REQ-022 RST asserted mid-WAIT_x SHALL abort the pending change without emitting a pulse.
REQ-023 A button held at 1 through reset release SHALL be accepted as a press DEBOUNCE_CYCLES+2 edges after the first edge with RST=0.
REQ-024 Reset SHALL take precedence over all other inputs.

Verification (DEBOUNCE_CYCLES=4, N_BTN=3)
REQ-025 Clean press: btn_raw[0] 0->1 sampled at edge 1 -> btn_level[0]=1 and btn_press[0]=1 after edge 6; btn_press[0]=0 after edge 7.
REQ-026 Bounce: btn_raw[1] toggles 1,0,1,0 (one cycle each), then holds 1 -> no pulse during toggling; exactly one btn_press[1] 6 edges after the final steady 1 is first sampled.
REQ-027 Release: from btn_level[2]=1, btn_raw[2]->0 steady -> btn_release[2] one cycle at edge 6, btn_level[2]=0, btn_press[2] never asserted.
REQ-028 Reset mid-wait: btn_raw[0]=1 for 3 cycles, then RST=1 for 1 cycle with btn_raw[0]=1 held -> all outputs 0; btn_press[0] occurs 6 edges after RST falls.
REQ-029 Simultaneous: btn_raw=3'b111 in one cycle -> btn_press=3'b111 for one cycle at edge 6, btn_level=3'b111 thereafter.
REQ-030 3-cycle glitch: btn_raw[0]=1 for 3 cycles, then 0 -> all outputs remain 0 for 20 cycles.

Source files
------------

// File: rtl/btn_conditioner.sv
// Debounced push-button conditioner: per-channel 2-flop sync,
// 4-state debounce FSM, registered level and press/release pulses.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  state_t           r_state     [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [CW-1:0]    r_cnt       [N_BTN];
  logic [CW-1:0]    w_cnt_nxt   [N_BTN];
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;

  // Two-flop synchronizer: the only consumer of the raw pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // Next state, counter and output pulses for every channel.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = '0;
      w_press[i]     = 1'b0;
      w_release[i]   = 1'b0;
      unique case (r_state[i])
        STABLE_LO: begin
          if (r_s2[i]) begin
            w_state_nxt[i] = WAIT_HI;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!r_s2[i]) begin
            w_state_nxt[i] = STABLE_LO;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = STABLE_HI;
            w_press[i]     = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!r_s2[i]) begin
            w_state_nxt[i] = WAIT_LO;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (r_s2[i]) begin
            w_state_nxt[i] = STABLE_HI;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = STABLE_LO;
            w_release[i]   = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
      endcase
      w_level[i] = (w_state_nxt[i] == STABLE_HI) ||
                   (w_state_nxt[i] == WAIT_LO);
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= STABLE_LO;
        r_cnt[i]   <= '0;
      end
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_level   <= w_level;
      r_press   <= w_press;
      r_release <= w_release;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (N_BTN=3, DEBOUNCE_CYCLES=4)
// with a run-length reference model and directed scenarios.
module tb_btn_conditioner;

  localparam int N = 3;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 CLK = ~CLK;

  // Reference: a pin value is seen two edges after it is sampled;
  // the level flips once D consecutive seen values disagree with it.
  logic [N-1:0] m_q1 = '0;
  logic [N-1:0] m_q2 = '0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel = '0;
  int           m_run [N];

  initial for (int c = 0; c < N; c++) m_run[c] = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_q1    <= '0;
      m_q2    <= '0;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      for (int c = 0; c < N; c++) m_run[c] <= 0;
    end else begin
      m_q1    <= btn_raw;
      m_q2    <= m_q1;
      m_press <= '0;
      m_rel   <= '0;
      for (int c = 0; c < N; c++) begin
        if (m_q2[c] != m_level[c]) begin
          if (m_run[c] + 1 == D) begin
            m_level[c] <= m_q2[c];
            m_press[c] <= m_q2[c];
            m_rel[c]   <= !m_q2[c];
            m_run[c]   <= 0;
          end else begin
            m_run[c] <= m_run[c] + 1;
          end
        end else begin
          m_run[c] <= 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    btn_raw = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      btn_raw = N'($urandom);
      @(negedge CLK);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        n_fail++;
        $display("FAIL reset cyc %0d got %b want 0", k,
                 {btn_level, btn_press, btn_release});
      end
    end
    RST = 1'b0;
    btn_raw = '0;
  endtask

  task automatic test_clean_press();
    do_reset();
    btn_raw = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      n_checks++;
      if (btn_press[0] !== 1'(k == 6)) begin
        n_fail++;
        $display("FAIL clean_press edge %0d got %b want %b",
                 k, btn_press[0], 1'(k == 6));
      end
      n_checks++;
      if (btn_level[0] !== 1'(k >= 6)) begin
        n_fail++;
        $display("FAIL clean_level edge %0d got %b want %b",
                 k, btn_level[0], 1'(k >= 6));
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] seq [4];
    seq = '{3'b010, 3'b000, 3'b010, 3'b000};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      btn_raw = seq[k];
      @(negedge CLK);
      n_checks++;
      if (btn_press !== '0) begin
        n_fail++;
        $display("FAIL bounce_toggle cyc %0d got %b want 000",
                 k, btn_press);
      end
    end
    btn_raw = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      n_checks++;
      if (btn_press !== ((k == 6) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL bounce_press edge %0d got %b want %b", k,
                 btn_press, (k == 6) ? 3'b010 : 3'b000);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    btn_raw = 3'b100;
    repeat (10) @(negedge CLK);
    n_checks++;
    if (btn_level !== 3'b100) begin
      n_fail++;
      $display("FAIL release_pre got %b want 100", btn_level);
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      n_checks++;
      if (btn_release[2] !== 1'(k == 6) || btn_press[2] !== 1'b0
          || btn_level[2] !== 1'(k < 6)) begin
        n_fail++;
        $display("FAIL release edge %0d got rel=%b prs=%b lvl=%b want rel=%b prs=0 lvl=%b",
                 k, btn_release[2], btn_press[2], btn_level[2],
                 1'(k == 6), 1'(k < 6));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    btn_raw = 3'b001;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== '0) begin
      n_fail++;
      $display("FAIL mid_wait_rst got %b want 0",
               {btn_level, btn_press, btn_release});
    end
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      n_checks++;
      if (btn_press[0] !== 1'(k == 6)) begin
        n_fail++;
        $display("FAIL mid_wait_press edge %0d got %b want %b",
                 k, btn_press[0], 1'(k == 6));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_raw = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      n_checks++;
      if (btn_press !== ((k == 6) ? 3'b111 : 3'b000) ||
          btn_level !== ((k >= 6) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL simul edge %0d got prs=%b lvl=%b", k,
                 btn_press, btn_level);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_raw = 3'b001;
    for (int k = 0; k < 23; k++) begin
      if (k == 3) btn_raw = 3'b000;
      @(negedge CLK);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        n_fail++;
        $display("FAIL glitch cyc %0d got %b want 0", k,
                 {btn_level, btn_press, btn_release});
      end
    end
  endtask

  task automatic test_random();
    int hold [N];
    logic [N-1:0] prev_pulse;
    prev_pulse = '0;
    for (int c = 0; c < N; c++) hold[c] = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_raw[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 9);
        end
        hold[c]--;
      end
      RST = ($urandom_range(0, 299) == 0);
      @(negedge CLK);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL random cyc %0d got %b want %b", k,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      n_checks++;
      if (((btn_press & btn_release) |
           ((btn_press | btn_release) & prev_pulse)) !== '0) begin
        n_fail++;
        $display("FAIL pulse_rule cyc %0d got prs=%b rel=%b prev=%b want no overlap",
                 k, btn_press, btn_release, prev_pulse);
      end
      prev_pulse = btn_press | btn_release;
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_reset_mid_wait();
    test_simultaneous();
    test_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
